// File: rtl/spi_target.sv
// SPI mode-0 target with a DATA/STATUS register pair on the 8-bit system bus.
// SPI pins are resynchronised into clock_sys; all frame state is clock_sys-domain.
module spi_target #(
  parameter logic [7:0] BASE_ADDR = 8'h20,
  parameter logic [7:0] IDLE_TX   = 8'hFF
) (
  input  logic       clock_sys,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       rw,
  input  logic       cs,
  output logic [7:0] data_out,
  output logic       data_out_en,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_en
);

  localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic       sck_s1, sck_s2, sck_prev;
  logic       csn_s1, csn_s2, csn_prev;
  logic       mosi_s1, mosi_s2;
  logic       bus_prev;
  logic [7:0] rx_data, tx_hold;
  logic [6:0] rx_shift, tx_shift;
  logic [2:0] count;
  logic       rx_full, tx_empty, overrun;

  logic       access, wr_data, rd_data, clr_ovr;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0] load_byte, rx_byte, status;

  always_ff @(posedge clock_sys or posedge reset) begin
    if (reset) begin
      sck_s1   <= 1'b0; sck_s2  <= 1'b0; sck_prev <= 1'b0;
      csn_s1   <= 1'b1; csn_s2  <= 1'b1; csn_prev <= 1'b1;
      mosi_s1  <= 1'b0; mosi_s2 <= 1'b0;
      bus_prev <= 1'b1;
    end else begin
      sck_s1   <= spi_sck;  sck_s2  <= sck_s1;  sck_prev <= sck_s2;
      csn_s1   <= spi_cs_n; csn_s2  <= csn_s1;  csn_prev <= csn_s2;
      mosi_s1  <= spi_mosi; mosi_s2 <= mosi_s1;
      bus_prev <= cs;
    end
  end

  assign access    = ~cs & bus_prev;
  assign wr_data   = access & ~rw & (addr == BASE_ADDR);
  assign rd_data   = access &  rw & (addr == BASE_ADDR);
  assign clr_ovr   = access & ~rw & (addr == STAT_ADDR) & data[2];
  assign sck_rise  =  sck_s2 & ~sck_prev;
  assign sck_fall  = ~sck_s2 &  sck_prev;
  assign cs_fall   = ~csn_s2 &  csn_prev;
  assign cs_rise   =  csn_s2 & ~csn_prev;
  assign load_byte = tx_empty ? IDLE_TX : tx_hold;
  assign rx_byte   = {rx_shift, mosi_s2};
  assign status    = {4'b0000, ~csn_s2, overrun, tx_empty, rx_full};

  assign data_out_en = ~cs & rw;

  always_comb begin
    data_out = '0;
    if (addr == BASE_ADDR)      data_out = rx_data;
    else if (addr == STAT_ADDR) data_out = status;
  end

  // Bus clears come first and a bus DATA write comes last, so a byte completing
  // during a DATA read keeps rx_full set and a write during a tx load still lands.
  always_ff @(posedge clock_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      spi_miso    <= 1'b0;
      spi_miso_en <= 1'b0;
      rx_data     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      rx_full     <= 1'b0;
      tx_empty    <= 1'b1;
      overrun     <= 1'b0;
      count       <= '0;
    end else begin
      if (rd_data) rx_full <= 1'b0;
      if (clr_ovr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            count       <= '0;
            spi_miso_en <= 1'b1;
            tx_shift    <= load_byte[6:0];
            spi_miso    <= load_byte[7];
            if (!tx_empty) tx_empty <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            count       <= '0;
            spi_miso_en <= 1'b0;
            spi_miso    <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_byte[6:0];
            if (count == 3'd7) begin
              count <= '0;
              if (!rx_full || rd_data) begin
                rx_data <= rx_byte;
                rx_full <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              count <= count + 3'd1;
            end
          end else if (sck_fall) begin
            if (count == 3'd0) begin
              tx_shift <= load_byte[6:0];
              spi_miso <= load_byte[7];
              if (!tx_empty) tx_empty <= 1'b1;
            end else begin
              tx_shift <= {tx_shift[5:0], 1'b0};
              spi_miso <= tx_shift[6];
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_data) begin
        tx_hold  <= data;
        tx_empty <= 1'b0;
      end
    end
  end

endmodule
